// File: rtl/freq_synth_acc.sv
//------------------------------------------------------------------------------
// Module   : freq_synth_acc
// Brief    : Programmable square-wave source; clk_fx produces fre_cur rising
//            edges per second using a Bresenham accumulator in Hz units.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module freq_synth_acc #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int ACC_W    = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] fre_set,
    input  logic        load,
    output logic        ack,
    output logic        clk_fx,
    output logic        running,
    output logic [31:0] fre_cur,
    output logic        ovr
);

    localparam logic [31:0]      c_HALF    = 32'(CLK_FREQ / 2);
    localparam logic [ACC_W-1:0] c_CLK_ACC = ACC_W'(CLK_FREQ);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_clk_fx;
    logic [31:0]      r_fre_cur;
    logic [31:0]      r_fre_pend;
    logic             r_pend;
    logic             r_ack;
    logic             r_ovr;

    logic [31:0]      w_clamp;
    logic [ACC_W-1:0] w_sum;
    logic             w_wrap;
    logic             w_fall;

    assign w_clamp = (fre_set > c_HALF) ? c_HALF : fre_set;
    assign w_sum   = r_acc + ACC_W'({r_fre_cur, 1'b0});
    assign w_wrap  = (w_sum >= c_CLK_ACC);
    // A wrap while high is the glitch-free point for switching frequency.
    assign w_fall  = r_clk_fx && w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_acc      <= '0;
            r_clk_fx   <= 1'b0;
            r_fre_cur  <= '0;
            r_fre_pend <= '0;
            r_pend     <= 1'b0;
            r_ack      <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_ack <= load;
            if (load) begin
                r_fre_pend <= w_clamp;
                r_ovr      <= (fre_set > c_HALF);
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_acc    <= '0;
                    r_clk_fx <= 1'b0;
                    // No output edge to protect, so a write takes effect at once.
                    if (load) begin
                        r_fre_cur <= w_clamp;
                        r_pend    <= 1'b0;
                    end else if (r_pend) begin
                        r_fre_cur <= r_fre_pend;
                        r_pend    <= 1'b0;
                    end
                    if (en && (r_fre_cur != 32'd0)) begin
                        r_state <= c_ST_RUN;
                    end
                end

                default: begin
                    if (!en || (r_fre_cur == 32'd0)) begin
                        r_state  <= c_ST_IDLE;
                        r_acc    <= '0;
                        r_clk_fx <= 1'b0;
                        if (load) begin
                            r_pend <= 1'b1;
                        end
                    end else if (w_fall && r_pend && !load) begin
                        r_fre_cur <= r_fre_pend;
                        r_pend    <= 1'b0;
                        r_acc     <= '0;
                        r_clk_fx  <= 1'b0;
                    end else begin
                        if (load) begin
                            r_pend <= 1'b1;
                        end
                        if (w_wrap) begin
                            r_acc    <= w_sum - c_CLK_ACC;
                            r_clk_fx <= ~r_clk_fx;
                        end else begin
                            r_acc <= w_sum;
                        end
                    end
                end
            endcase
        end
    end

    assign ack     = r_ack;
    assign clk_fx  = r_clk_fx;
    assign running = (r_state == c_ST_RUN);
    assign fre_cur = r_fre_cur;
    assign ovr     = r_ovr;

endmodule

`default_nettype wire
